// File: rtl/profile_ci_master_pkg.sv
// Shared types and constants for the profile counter snapshot master.
// FSM state encoding, counter-index width and control-word field positions.
package profile_ci_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int IDX_W   = 2;
   localparam int NUM_CNT = 4;
   localparam logic [IDX_W-1:0] IDX_LAST = 2'd3;

   localparam int CTRL_EN_LSB = 0;
   localparam int CTRL_EN_MSB = 3;
   localparam int CTRL_FRZ_LSB = 4;
   localparam int CTRL_FRZ_MSB = 7;
   localparam int CTRL_CLR_LSB = 8;
   localparam int CTRL_CLR_MSB = 11;

endpackage

// File: rtl/profile_ci_master_if.sv
// Custom-instruction bus between the snapshot master and the counter block.
interface profile_ci_master_if;

   logic        ciStart;
   logic [7:0]  ciCIn;
   logic [31:0] ciValueA;
   logic [31:0] ciValueB;
   logic        ciDone;
   logic [31:0] ciResult;

   modport master (
      output ciStart, ciCIn, ciValueA, ciValueB,
      input  ciDone, ciResult
   );

   modport slave (
      input  ciStart, ciCIn, ciValueA, ciValueB,
      output ciDone, ciResult
   );

endinterface

// File: rtl/profile_timeout.sv
// Wait counter for one custom-instruction read; flags the last allowed cycle.
module profile_timeout #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_run,
   output logic o_expired
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_run) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Expires on the TIMEOUT-th consecutive cycle without ciDone.
   assign o_expired = i_run && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/profile_ci_master.sv
// Snapshots four profile counters over the custom-instruction bus.
// Optional read timeout: define PROFILE_MASTER_TIMEOUT_EN.
module profile_ci_master
   import profile_ci_master_pkg::*;
#(
   parameter logic [7:0] customId = 8'h00,
   parameter int         TIMEOUT  = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        trigger,
   input  logic [31:0] ctrlValue,
   output logic        busy,
   output logic        snapValid,
   output logic [31:0] snap0,
   output logic [31:0] snap1,
   output logic [31:0] snap2,
   output logic [31:0] snap3,
   output logic        error,
   profile_ci_master_if.master ci
);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [31:0]      r_ctrl;
   logic [31:0]      r_snap [NUM_CNT];
   logic             r_start;
   logic             r_busy;
   logic             r_snap_valid;
   logic             w_expired;

`ifdef PROFILE_MASTER_TIMEOUT_EN
   logic r_error;
   logic w_tmo_clear;
   logic w_tmo_run;

   assign w_tmo_clear = ((r_state == IDLE) && trigger) || ci.ciDone;
   assign w_tmo_run   = (r_state == READ) && !ci.ciDone;

   profile_timeout #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk      (clock),
      .rst      (reset),
      .i_clear  (w_tmo_clear),
      .i_run    (w_tmo_run),
      .o_expired(w_expired)
   );

   assign error = r_error;
`else
   localparam int unused_timeout = TIMEOUT;
   assign w_expired = 1'b0;
   assign error     = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_ctrl       <= '0;
         r_start      <= 1'b0;
         r_busy       <= 1'b0;
         r_snap_valid <= 1'b0;
         for (int i = 0; i < NUM_CNT; i++) r_snap[i] <= '0;
`ifdef PROFILE_MASTER_TIMEOUT_EN
         r_error      <= 1'b0;
`endif
      end else begin
         r_snap_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (trigger) begin
                  r_ctrl  <= ctrlValue;
                  r_idx   <= '0;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= READ;
`ifdef PROFILE_MASTER_TIMEOUT_EN
                  r_error <= 1'b0;
`endif
               end
            end
            READ: begin
               if (ci.ciDone) begin
                  r_snap[r_idx] <= ci.ciResult;
                  if (r_idx == IDX_LAST) begin
                     r_start      <= 1'b0;
                     r_snap_valid <= 1'b1;
                     r_state      <= FINISH;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else if (w_expired) begin
                  // Abandon the snapshot; partial captures stay visible.
                  r_start <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
`ifdef PROFILE_MASTER_TIMEOUT_EN
                  r_error <= 1'b1;
`endif
               end
            end
            FINISH: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_start <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign snapValid = r_snap_valid;
   assign snap0     = r_snap[0];
   assign snap1     = r_snap[1];
   assign snap2     = r_snap[2];
   assign snap3     = r_snap[3];

   assign ci.ciStart  = r_start;
   assign ci.ciCIn    = customId;
   assign ci.ciValueA = r_start ? {{(32-IDX_W){1'b0}}, r_idx} : 32'h0;
   assign ci.ciValueB = r_start ? r_ctrl : 32'h0;

endmodule

// File: tb/tb_profile_ci_master.sv
// Directed bench for profile_ci_master with a snapshot scoreboard.
module tb_profile_ci_master;

   logic        clock;
   logic        reset;
   logic        trigger;
   logic [31:0] ctrlValue;
   logic        busy;
   logic        snapValid;
   logic [31:0] snap0, snap1, snap2, snap3;
   logic        error;

   profile_ci_master_if ifc ();

   profile_ci_master #(
      .customId(8'h00),
      .TIMEOUT (16)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .trigger  (trigger),
      .ctrlValue(ctrlValue),
      .busy     (busy),
      .snapValid(snapValid),
      .snap0    (snap0),
      .snap1    (snap1),
      .snap2    (snap2),
      .snap3    (snap3),
      .error    (error),
      .ci       (ifc)
   );

   int errors = 0;
   int checks = 0;

`define CHK(tag, obs, exp) \
   begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
         errors++; \
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
      end \
   end

   // Responder model: counter values, per-read delay, accepted ID.
   logic [31:0] cnt [4];
   int          rsp_delay;
   int          rsp_wait;
   logic [7:0]  rsp_id;
   logic        rsp_en;

   always_comb begin
      ifc.ciDone = rsp_en && ifc.ciStart && (ifc.ciCIn == rsp_id)
                   && (rsp_wait >= rsp_delay);
      ifc.ciResult = ifc.ciDone ? cnt[ifc.ciValueA[1:0]] : 32'h0;
   end

   always_ff @(posedge clock) begin
      if (!ifc.ciStart || ifc.ciDone) rsp_wait <= 0;
      else rsp_wait <= rsp_wait + 1;
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [3:0][31:0] sb_q [$];
   logic [3:0][31:0] last_snap;

   task automatic push_expected();
      sb_q.push_back({cnt[3], cnt[2], cnt[1], cnt[0]});
   endtask

   task automatic pulse(input logic [31:0] v);
      @(negedge clock);
      trigger   = 1'b1;
      ctrlValue = v;
      @(posedge clock);
      #1 trigger = 1'b0;
   endtask

   // Cycle 1 is the first cycle after the trigger edge.
   task automatic run_snap(input int budget, input logic [31:0] exp_b,
                           input int retrig, output int n_start,
                           output int v_at);
      int k;
      logic seen;
      logic [3:0][31:0] exp;
      k = 0; n_start = 0; v_at = 0; seen = 1'b0;
      for (int c = 1; c <= budget && !seen; c++) begin
         @(negedge clock);
         if (retrig != 0 && c == retrig) begin
            trigger = 1'b1; ctrlValue = 32'hFFFF;
         end
         if (retrig != 0 && c == retrig + 1) begin
            trigger = 1'b0; ctrlValue = exp_b;
         end
         if (ifc.ciStart) begin
            n_start++;
            if (ifc.ciDone) begin
               `CHK("valueA", ifc.ciValueA, 32'(k))
               `CHK("valueB", ifc.ciValueB, exp_b)
               k++;
            end
         end
         if (snapValid) begin
            seen = 1'b1;
            v_at = c;
            `CHK("sb_nonempty", (sb_q.size() > 0), 1'b1)
            if (sb_q.size() > 0) begin
               exp = sb_q.pop_front();
               last_snap = exp;
               `CHK("snap0", snap0, exp[0])
               `CHK("snap1", snap1, exp[1])
               `CHK("snap2", snap2, exp[2])
               `CHK("snap3", snap3, exp[3])
            end
         end
      end
      `CHK("snap_seen", seen, 1'b1)
      `CHK("reads", k, 4)
      if (seen) begin
         @(negedge clock);
         `CHK("valid_1cyc", snapValid, 1'b0)
         `CHK("busy_done", busy, 1'b0)
      end
   endtask

   int ns, va, nbad, nread;

   initial begin
      reset = 1'b1; trigger = 1'b0; ctrlValue = 32'h0;
      rsp_delay = 0; rsp_id = 8'h00; rsp_en = 1'b1;
      cnt[0] = 32'd5; cnt[1] = 32'd6; cnt[2] = 32'd7; cnt[3] = 32'd8;
      last_snap = '0;
      #2;
      `CHK("rst_busy", busy, 1'b0)
      `CHK("rst_valid", snapValid, 1'b0)
      `CHK("rst_start", ifc.ciStart, 1'b0)
      `CHK("rst_error", error, 1'b0)
      `CHK("rst_snap0", snap0, 32'h0)
      `CHK("rst_snap3", snap3, 32'h0)
      `CHK("rst_valA", ifc.ciValueA, 32'h0)
      `CHK("rst_valB", ifc.ciValueB, 32'h0)
      `CHK("cin", ifc.ciCIn, 8'h00)
      @(negedge clock);
      reset = 1'b0;

      // Zero-wait responder: 4 start cycles, snapValid in cycle 5.
      push_expected();
      pulse(32'h0000_000F);
      run_snap(20, 32'h0000_000F, 0, ns, va);
      `CHK("zw_start_cycles", ns, 4)
      `CHK("zw_valid_at", va, 5)

      // Two-cycle delay per read plus an ignored retrigger.
      cnt[0] = 32'h1111_0001; cnt[1] = 32'h2222_0002;
      cnt[2] = 32'h3333_0003; cnt[3] = 32'h4444_0004;
      rsp_delay = 2;
      push_expected();
      pulse(32'h0000_000F);
      run_snap(30, 32'h0000_000F, 1, ns, va);
      `CHK("dl_start_cycles", ns, 12)
      `CHK("dl_valid_at", va, 13)
      repeat (2) @(negedge clock);
      `CHK("no_queued_trig", busy, 1'b0)

      // Reset in the middle of READ.
      cnt[0] = 32'hAAAA_0000;
      pulse(32'h0000_0003);
      repeat (2) @(negedge clock);
      @(posedge clock);
      #1;
      `CHK("pre_rst_start", ifc.ciStart, 1'b1)
      reset = 1'b1;
      #1;
      `CHK("mid_rst_start", ifc.ciStart, 1'b0)
      `CHK("mid_rst_busy", busy, 1'b0)
      `CHK("mid_rst_snap0", snap0, 32'h0)
      `CHK("mid_rst_snap1", snap1, 32'h0)
      `CHK("mid_rst_snap2", snap2, 32'h0)
      `CHK("mid_rst_snap3", snap3, 32'h0)
      @(negedge clock);
      reset = 1'b0;
      nbad = 0;
      repeat (8) begin
         @(negedge clock);
         if (snapValid || busy) nbad++;
      end
      `CHK("post_rst_quiet", nbad, 0)

      // Second pattern; snap registers must hold afterwards.
      cnt[0] = 32'hDEAD_BEEF; cnt[1] = 32'h0000_0000;
      cnt[2] = 32'hFFFF_FFFF; cnt[3] = 32'h8000_0001;
      rsp_delay = 0;
      push_expected();
      pulse(32'h0000_0A5F);
      run_snap(20, 32'h0000_0A5F, 0, ns, va);
      `CHK("p2_valid_at", va, 5)
      repeat (5) @(negedge clock);
      `CHK("hold_snap0", snap0, last_snap[0])
      `CHK("hold_snap2", snap2, last_snap[2])
      `CHK("hold_snap3", snap3, last_snap[3])

`ifdef PROFILE_MASTER_TIMEOUT_EN
      // Responder silent: abort after 16 READ cycles.
      rsp_en = 1'b0;
      pulse(32'h0000_000F);
      nread = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (!busy) break;
         nread++;
      end
      `CHK("tmo_cycles", nread, 16)
      `CHK("tmo_error", error, 1'b1)
      `CHK("tmo_snap0", snap0, last_snap[0])
      `CHK("tmo_snap3", snap3, last_snap[3])
      rsp_en = 1'b1;
      push_expected();
      pulse(32'h0000_000F);
      `CHK("tmo_err_clr", error, 1'b0)
      run_snap(20, 32'h0000_000F, 0, ns, va);
`else
      // Wrong ID with no timeout: stuck in READ forever.
      rsp_id = 8'h01;
      pulse(32'h0000_000F);
      nread = 0;
      repeat (40) begin
         @(negedge clock);
         if (busy && ifc.ciStart) nread++;
      end
      `CHK("wid_busy_cycles", nread, 40)
      `CHK("wid_error", error, 1'b0)
      reset = 1'b1;
      #1;
      `CHK("wid_rst_busy", busy, 1'b0)
      @(negedge clock);
      reset = 1'b0;
      rsp_id = 8'h00;
`endif

      `CHK("sb_drained", sb_q.size(), 0)
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
